// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter that lets N requesters share one
// W-bit loadable register. A winner is chosen in IDLE. Its data and index
// are registered. The following GRANT cycle drives a one-cycle write strobe
// and a one-hot acknowledge.
// Optional feature macro: ARB_LOCK_EN. When it is defined, a winner that
// has its lock bit high keeps top priority for the next arbitration.
module reg_share_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         ack,
    output logic                 reg_load,
    output logic [W-1:0]         reg_d,
    output logic [$clog2(N)-1:0] owner
);

    localparam int            OW  = $clog2(N);
    localparam int            OW1 = OW + 1;
    localparam logic [OW:0]   N_L = OW1'(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            load_q, load_d;
    logic [W-1:0]    data_q, data_d;

    logic [W-1:0]    data_arr [N];
    logic            found;
    logic [OW-1:0]   winner;
    logic [OW:0]     cand;
    logic [OW:0]     nxt;

    // Unpack the flat request data bus into one word per requester.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*W +: W];
    end

`ifndef ARB_LOCK_EN
    // The lock hint has no effect in the plain round-robin build.
    logic lock_unused;
    assign lock_unused = ^lock;
`endif

    // Round-robin search: the first requester at or after ptr, with wrap, wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + OW1'(k);
            if (cand >= N_L) begin
                cand = cand - N_L;
            end
            if (!found && req[cand[OW-1:0]]) begin
                found  = 1'b1;
                winner = cand[OW-1:0];
            end
        end
    end

    // Next-state logic: IDLE registers a winner, and GRANT always lasts one cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        load_d  = 1'b0;
        nxt     = {1'b0, winner} + OW1'(1);
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = GRANT;
                    ack_d[winner]  = 1'b1;
                    load_d         = 1'b1;
                    data_d         = data_arr[winner];
                    owner_d        = winner;
                    ptr_d          = (nxt == N_L) ? '0 : nxt[OW-1:0];
`ifdef ARB_LOCK_EN
                    // A locking winner stays at the head of the search order.
                    if (lock[winner]) begin
                        ptr_d = winner;
                    end
`endif
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. The asynchronous reset clears every
    // register, so an interrupted grant never completes a partial write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            data_q  <= data_d;
        end
    end

    assign ack      = ack_q;
    assign reg_load = load_q;
    assign reg_d    = data_q;
    assign owner    = owner_q;

endmodule
